// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - truth-table sweep/capture harness for a 4-input AIG netlist (optional EARLY_EXIT_EN)
module tt_sweep_capture #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] exp_tt,
  output logic        x0,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  input  logic        y0,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic [3:0]  fail_idx
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_exp;
  logic [3:0]  r_m;
  logic [7:0]  r_cnt;
  logic [3:0]  r_x;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_tt;
  logic        r_match;
  logic        r_fail;
  logic [3:0]  r_fail_idx;

  logic        w_last_settle;
  logic        w_mis;
  logic        w_exit;

  // y0 has been stable for SETTLE_CYCLES cycles once the counter hits its terminal value
  assign w_last_settle = (r_cnt == 8'(SETTLE_CYCLES - 1));
  assign w_mis         = (y0 != r_exp[r_m]);

`ifdef EARLY_EXIT_EN
  assign w_exit = w_mis;
`else
  assign w_exit = 1'b0;
`endif

  // Sweep sequencer: drives the minterm, samples y0 and accumulates the verdict
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_exp      <= 16'h0000;
      r_m        <= 4'd0;
      r_cnt      <= 8'd0;
      r_x        <= 4'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tt       <= 16'h0000;
      r_match    <= 1'b0;
      r_fail     <= 1'b0;
      r_fail_idx <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_exp      <= exp_tt;
            r_tt       <= 16'h0000;
            r_m        <= 4'd0;
            r_x        <= 4'd0;
            r_cnt      <= 8'd0;
            r_busy     <= 1'b1;
            r_match    <= 1'b0;
            r_fail     <= 1'b0;
            r_fail_idx <= 4'd0;
            r_state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_last_settle) begin
            r_tt[r_m] <= y0;
            if (w_mis && !r_fail) begin
              r_fail     <= 1'b1;
              r_fail_idx <= r_m;
            end
            if (r_m == 4'd15 || w_exit) begin
              // x is left on the last driven minterm until the next start
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_match <= !(r_fail || w_mis);
            end else begin
              r_m   <= r_m + 4'd1;
              r_x   <= r_m + 4'd1;
              r_cnt <= 8'd0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_FINISH: begin
          // start is deliberately ignored here; it is honoured from the next cycle
          r_done  <= 1'b0;
          r_m     <= 4'd0;
          r_cnt   <= 8'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign x0       = r_x[0];
  assign x1       = r_x[1];
  assign x2       = r_x[2];
  assign x3       = r_x[3];
  assign busy     = r_busy;
  assign done     = r_done;
  assign tt       = r_tt;
  assign match    = r_match;
  assign fail_idx = r_fail_idx;

endmodule
